fu_alu_arbiter: RTL and testbench

Shares the single one-cycle ALU functional unit among NUM_REQ requesters (reservation-station or issue slots) using round-robin arbitration.
- Pulses the FU's enable for exactly one cycle per operation and captures its result on finish.
- Holds the result, tag and flags in an output register until the writeback/common-data-bus stage accepts them.
- Sits between the issue stage and the FU_ALU instance; the FU itself is unchanged.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/fu_alu_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fu_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU functional unit and its arbiter:
// opcode values, datapath widths and the arbiter FSM state encoding.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  // ALU opcodes as understood by the FU. Anything else produces result 0.
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'd3;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'd4;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'd6;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'd7;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'd9;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [CTRL_W-1:0] ALU_AP4  = 4'd11;
  localparam logic [CTRL_W-1:0] ALU_BOUT = 4'd12;

  // Arbiter FSM: IDLE (no op), BUSY (op inside the FU), DONE (result held).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts at ptr+1 and wraps,
// so the requester named by ptr (the previous winner) has lowest priority.
// The pointer register itself belongs to the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // First set request bit after ptr, in wrap-around order; nothing when en=0.
  always_comb begin
    int  cand;
    logic hit;
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (en && !hit && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
        hit         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fu_alu_arbiter.sv
// Shares one single-cycle ALU functional unit among NUM_REQ issue slots.
// A round-robin winner gets a one-cycle enable pulse into the FU; the FU
// result is captured on finish and held, with its tag and source index,
// until the writeback stage accepts it. A new op may issue in the very
// cycle the held result is accepted.
module fu_alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int SRC_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  // issue-side requesters
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*CTRL_W-1:0]  req_ctrl,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  // FU interface
  output logic                       alu_en,
  output logic [CTRL_W-1:0]          alu_ctrl,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic [DATA_W-1:0]          alu_res,
  input  logic                       alu_zero,
  input  logic                       alu_overflow,
  input  logic                       alu_finish,
  // writeback side
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_res,
  output logic                       wb_zero,
  output logic                       wb_overflow,
  output logic [TAG_W-1:0]           wb_tag,
  output logic [SRC_W-1:0]           wb_src
);

  // Per-requester views of the flattened input buses.
  logic [CTRL_W-1:0] ctrl_arr [NUM_REQ];
  logic [DATA_W-1:0] a_arr    [NUM_REQ];
  logic [DATA_W-1:0] b_arr    [NUM_REQ];
  logic [TAG_W-1:0]  tag_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign ctrl_arr[gi] = req_ctrl[CTRL_W*gi +: CTRL_W];
      assign a_arr[gi]    = req_a[DATA_W*gi +: DATA_W];
      assign b_arr[gi]    = req_b[DATA_W*gi +: DATA_W];
      assign tag_arr[gi]  = req_tag[TAG_W*gi +: TAG_W];
    end
  endgenerate

  arb_state_t        state_reg, state_next;
  logic [SRC_W-1:0]  ptr_reg;
  logic [TAG_W-1:0]  op_tag_reg;
  logic [SRC_W-1:0]  op_src_reg;
  logic              wb_valid_reg, wb_valid_next;
  logic [DATA_W-1:0] wb_res_reg;
  logic              wb_zero_reg;
  logic              wb_overflow_reg;
  logic [TAG_W-1:0]  wb_tag_reg;
  logic [SRC_W-1:0]  wb_src_reg;

  logic              slot_free;
  logic              issue;
  logic              capture;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]  win_idx;

  // The FU slot is free when nothing is in flight and no result is held,
  // or the held result is being accepted this very cycle.
  assign slot_free = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_DONE) && wb_ready);

  // Issuing while the FU still reports finish would be dropped by the FU,
  // so alu_finish blocks issue. Reset also blocks it so no handshake is
  // accepted during a cycle whose state is being discarded.
  assign issue = slot_free && (|req_valid) && !alu_finish && !flush && !rst;

  // A finish only counts while an op is genuinely in flight.
  assign capture = (state_reg == ST_BUSY) && alu_finish && !flush;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .en    (issue),
    .grant (grant),
    .idx   (win_idx)
  );

  assign req_ready = grant;
  assign alu_en    = issue;

  // Operand mux into the FU; zero when not issuing.
  always_comb begin
    alu_ctrl = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (issue) begin
      alu_ctrl = ctrl_arr[win_idx];
      alu_a    = a_arr[win_idx];
      alu_b    = b_arr[win_idx];
    end
  end

  // Next-state and wb_valid logic; flush overrides everything.
  always_comb begin
    state_next    = state_reg;
    wb_valid_next = wb_valid_reg;
    if (flush) begin
      state_next    = ST_IDLE;
      wb_valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (issue) begin
            state_next = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (alu_finish) begin
            state_next    = ST_DONE;
            wb_valid_next = 1'b1;
          end
        end
        ST_DONE: begin
          if (wb_ready) begin
            wb_valid_next = 1'b0;
            state_next    = issue ? ST_BUSY : ST_IDLE;
          end
        end
        default: begin
          state_next    = ST_IDLE;
          wb_valid_next = 1'b0;
        end
      endcase
    end
  end

  // State, pointer, in-flight tag/src and held writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= SRC_W'(NUM_REQ - 1);
      op_tag_reg      <= '0;
      op_src_reg      <= '0;
      wb_valid_reg    <= 1'b0;
      wb_res_reg      <= '0;
      wb_zero_reg     <= 1'b0;
      wb_overflow_reg <= 1'b0;
      wb_tag_reg      <= '0;
      wb_src_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      wb_valid_reg <= wb_valid_next;
      if (issue) begin
        ptr_reg    <= win_idx;
        op_tag_reg <= tag_arr[win_idx];
        op_src_reg <= win_idx;
      end
      if (capture) begin
        wb_res_reg      <= alu_res;
        wb_zero_reg     <= alu_zero;
        wb_overflow_reg <= alu_overflow;
        wb_tag_reg      <= op_tag_reg;
        wb_src_reg      <= op_src_reg;
      end
    end
  end

  assign wb_valid    = wb_valid_reg;
  assign wb_res      = wb_res_reg;
  assign wb_zero     = wb_zero_reg;
  assign wb_overflow = wb_overflow_reg;
  assign wb_tag      = wb_tag_reg;
  assign wb_src      = wb_src_reg;

endmodule

// File: tb/tb_fu_alu_arbiter.sv
// Bench for fu_alu_arbiter: a stand-in one-cycle FU, an operation-level
// reference model compared on every negative edge, directed scenarios with
// literal expectations, then a randomized run.
module tb_fu_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*4-1:0]    req_ctrl;
  logic [N*32-1:0]   req_a, req_b;
  logic [N*TW-1:0]   req_tag;
  logic              alu_en;
  logic [3:0]        alu_ctrl;
  logic [31:0]       alu_a, alu_b, alu_res;
  logic              alu_zero, alu_overflow, alu_finish;
  logic              wb_valid, wb_ready;
  logic [31:0]       wb_res;
  logic              wb_zero, wb_overflow;
  logic [TW-1:0]     wb_tag;
  logic [SW-1:0]     wb_src;

  fu_alu_arbiter #(.NUM_REQ(N), .TAG_W(TW), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_en(alu_en), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_finish(alu_finish),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_res(wb_res),
    .wb_zero(wb_zero), .wb_overflow(wb_overflow), .wb_tag(wb_tag),
    .wb_src(wb_src)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural ALU behaviour: {overflow, zero, result}.
  function automatic logic [33:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    r = '0;
    v = 1'b0;
    case (c)
      ALU_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'b0, (a < b)};
      ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
      ALU_AP4:  r = a + 32'd4;
      ALU_BOUT: r = b;
      default:  r = '0;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  // Stand-in FU: latches on EN while idle, reports finish the next cycle.
  logic        fu_state = 1'b0;
  logic [3:0]  fu_c = '0;
  logic [31:0] fu_a = '0, fu_b = '0;
  logic        force_finish;

  always @(posedge clk) begin
    if (alu_en && !fu_state) begin
      fu_state <= 1'b1;
      fu_c     <= alu_ctrl;
      fu_a     <= alu_a;
      fu_b     <= alu_b;
    end else begin
      fu_state <= 1'b0;
    end
  end

  assign alu_finish = fu_state | force_finish;
  assign {alu_overflow, alu_zero, alu_res} = alu_fn(fu_c, fu_a, fu_b);

  // Reference model: which requester last won, whether an op is in flight,
  // and what result (if any) is waiting for writeback.
  int          m_last;
  bit          m_inflight, m_held;
  logic [3:0]  m_c;
  logic [31:0] m_a, m_b;
  logic [TW-1:0] m_tag, m_wb_tag;
  logic [SW-1:0] m_src, m_wb_src;
  logic [33:0] m_wb;

  function automatic int pick_winner();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit model_issue();
    return !rst && !flush && !alu_finish && (|req_valid) && !m_inflight &&
           (!m_held || wb_ready);
  endfunction

  // Compare DUT to model each cycle, then advance the model for the coming edge.
  initial begin
    bit iss;
    int w;
    logic [N-1:0] exp_ready;
    m_last = N - 1; m_inflight = 0; m_held = 0;
    m_c = '0; m_a = '0; m_b = '0; m_tag = '0; m_src = '0;
    m_wb = '0; m_wb_tag = '0; m_wb_src = '0;
    forever begin
      @(negedge clk);
      iss = model_issue();
      w   = pick_winner();
      exp_ready = iss ? N'(1 << w) : '0;
      check("m_req_ready", 64'(req_ready), 64'(exp_ready));
      check("m_alu_en", 64'(alu_en), 64'(iss));
      if (iss) begin
        check("m_alu_ctrl", 64'(alu_ctrl), 64'(req_ctrl[4*w +: 4]));
        check("m_alu_a", 64'(alu_a), 64'(req_a[32*w +: 32]));
        check("m_alu_b", 64'(alu_b), 64'(req_b[32*w +: 32]));
      end else begin
        check("m_alu_idle_ops", {28'b0, alu_ctrl, alu_a | alu_b}, 64'd0);
      end
      check("m_wb_valid", 64'(wb_valid), 64'(m_held));
      if (m_held) begin
        check("m_wb_res", 64'(wb_res), 64'(m_wb[31:0]));
        check("m_wb_flags", {62'b0, wb_overflow, wb_zero}, {62'b0, m_wb[33], m_wb[32]});
        check("m_wb_tag", 64'(wb_tag), 64'(m_wb_tag));
        check("m_wb_src", 64'(wb_src), 64'(m_wb_src));
      end
      if (rst) begin
        m_last = N - 1; m_inflight = 0; m_held = 0;
      end else if (flush) begin
        m_inflight = 0; m_held = 0;
      end else begin
        if (m_inflight && alu_finish) begin
          m_inflight = 0; m_held = 1;
          m_wb = alu_fn(m_c, m_a, m_b);
          m_wb_tag = m_tag; m_wb_src = m_src;
        end else if (m_held && wb_ready) begin
          m_held = 0;
        end
        if (iss) begin
          m_inflight = 1;
          m_c   = req_ctrl[4*w +: 4];
          m_a   = req_a[32*w +: 32];
          m_b   = req_b[32*w +: 32];
          m_tag = req_tag[TW*w +: TW];
          m_src = SW'(w);
          m_last = w;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] t);
    req_valid[i]       = 1'b1;
    req_ctrl[4*i +: 4] = c;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_tag[TW*i +: TW] = t;
  endtask

  task automatic all_valid();
    for (int i = 0; i < N; i++) set_req(i, ALU_ADD, 32'(i), 32'(i + 10), TW'(i));
  endtask

  initial begin
    int k;
    rst = 1'b1; flush = 1'b0; force_finish = 1'b0; wb_ready = 1'b1;
    req_valid = '0; req_ctrl = '0; req_a = '0; req_b = '0; req_tag = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_wb", {wb_res, 26'b0, wb_valid, wb_zero, wb_overflow, wb_tag[2:0]}, 64'd0);
    check("reset_wb_tag_src", {58'b0, wb_tag, wb_src}, 64'd0);
    check("reset_idle_out", {59'b0, alu_en, req_ready}, 64'd0);

    // Single ADD from requester 0
    set_req(0, ALU_ADD, 32'd5, 32'd7, 4'd3);
    #1;
    check("t1_alu_en", 64'(alu_en), 64'd1);
    check("t1_grant", 64'(req_ready), 64'd1);
    step(); req_valid = '0; #1;
    check("t1_en_pulse", 64'(alu_en), 64'd0);
    check("t1_no_wb_yet", 64'(wb_valid), 64'd0);
    step(); #1;
    check("t1_wb_valid", 64'(wb_valid), 64'd1);
    check("t1_wb_res", 64'(wb_res), 64'd12);
    check("t1_wb_zero", 64'(wb_zero), 64'd0);
    check("t1_wb_tag", 64'(wb_tag), 64'd3);
    check("t1_wb_src", 64'(wb_src), 64'd0);

    // Signed overflow and zero result from requester 2
    set_req(2, ALU_SUB, 32'h8000_0000, 32'd1, 4'd5);
    #1;
    check("t2_grant", 64'(req_ready), 64'd4);
    step(); req_valid = '0; step(); #1;
    check("t2_res", 64'(wb_res), 64'h7FFF_FFFF);
    check("t2_ovf", 64'(wb_overflow), 64'd1);
    check("t2_src", 64'(wb_src), 64'd2);
    set_req(2, ALU_SUB, 32'd9, 32'd9, 4'd6);
    step(); req_valid = '0; step(); #1;
    check("t2_zero_res", 64'(wb_res), 64'd0);
    check("t2_zero_flag", 64'(wb_zero), 64'd1);
    check("t2_zero_ovf", 64'(wb_overflow), 64'd0);
    step();

    // Round-robin order with all requesters held valid
    do_reset();
    all_valid();
    wb_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (alu_en) begin
        check("t3_rr_grant", 64'(req_ready), 64'(1 << (k % N)));
        k++;
      end
      step();
    end
    check("t3_issue_count", 64'(k), 64'd5);
    req_valid = '0;

    // Backpressure: held result stays put, then same-cycle reissue
    do_reset();
    set_req(0, ALU_ADD, 32'd1, 32'd2, 4'd7);
    wb_ready = 1'b0;
    step(); req_valid = '0; step();
    set_req(1, ALU_XOR, 32'd3, 32'd5, 4'd9);
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      check("t4_hold_valid", 64'(wb_valid), 64'd1);
      check("t4_hold_res_tag", {28'b0, wb_tag, wb_res}, {28'b0, 4'd7, 32'd3});
      check("t4_blocked", {59'b0, alu_en, req_ready}, 64'd0);
      step();
    end
    wb_ready = 1'b1;
    #1;
    check("t4_reissue_en", 64'(alu_en), 64'd1);
    check("t4_reissue_grant", 64'(req_ready), 64'd2);
    step(); req_valid = '0; step(); #1;
    check("t4_second_res", 64'(wb_res), 64'd6);
    check("t4_second_src", 64'(wb_src), 64'd1);
    check("t4_second_tag", 64'(wb_tag), 64'd9);
    step();

    // Stale finish blocks issue and produces no result
    do_reset();
    force_finish = 1'b1;
    set_req(1, ALU_OR, 32'hF0, 32'h0F, 4'd2);
    #1;
    check("t5_blocked", {59'b0, alu_en, req_ready}, 64'd0);
    step(); force_finish = 1'b0; #1;
    check("t5_grant", 64'(req_ready), 64'd2);
    check("t5_no_wb", 64'(wb_valid), 64'd0);
    step(); req_valid = '0; step(); #1;
    check("t5_res", 64'(wb_res), 64'hFF);
    step();

    // Flush in BUSY, then reset in DONE
    do_reset();
    set_req(1, ALU_ADD, 32'd1, 32'd1, 4'd1);
    step(); req_valid = '0; flush = 1'b1; #1;
    check("t6_flush_no_en", 64'(alu_en), 64'd0);
    step(); flush = 1'b0; #1;
    check("t6_flush_no_wb", 64'(wb_valid), 64'd0);
    step(); #1;
    check("t6_flush_no_wb2", 64'(wb_valid), 64'd0);
    all_valid();
    #1;
    check("t6_ptr_kept", 64'(req_ready), 64'd4);
    step(); req_valid = '0; step(); #1;
    check("t6_wb_src", 64'(wb_src), 64'd2);
    wb_ready = 1'b0;
    do_reset();
    #1;
    check("t6_rst_wb", {wb_res, 26'b0, wb_valid, wb_zero, wb_overflow, wb_tag[2:0]}, 64'd0);
    check("t6_rst_tag_src", {58'b0, wb_tag, wb_src}, 64'd0);
    all_valid();
    wb_ready = 1'b1;
    #1;
    check("t6_rst_grant", 64'(req_ready), 64'd1);
    step(); req_valid = '0; step(); step();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst          = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 49) == 0);
      force_finish = ($urandom_range(0, 19) == 0);
      wb_ready     = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i]        = ($urandom_range(0, 2) != 0);
        req_ctrl[4*i +: 4]  = 4'($urandom_range(0, 15));
        req_a[32*i +: 32]   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        req_b[32*i +: 32]   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        req_tag[TW*i +: TW] = TW'($urandom);
      end
      step();
    end
    rst = 1'b0; flush = 1'b0; force_finish = 1'b0; req_valid = '0; wb_ready = 1'b1;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
